serial_sub16: RTL

Bit-serial 16-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first. It is the inverse-direction counterpart of the team's ripple-carry adder, sized for area-constrained datapaths where a full-width combinational unit is not justified. A start/busy/done handshake lets a sequencing controller issue one operation at a time. Results are held stable until the next accepted start.

---
 rtl/serial_sub16.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/serial_sub16.sv
// -----------------------------------------------------------------------------
// serial_sub16
//   Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   A start/busy/done handshake accepts one operation at a time. Results are
//   held until the next accepted start.
//
// Ports
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high while the serial operation runs
//   done   out  1      one-cycle pulse when the result becomes valid
//   diff   out  WIDTH  difference (mod 2^WIDTH)
//   bout   out  1      unsigned borrow-out
//   ovf    out  1      signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_brw;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_brw_next;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf;

    // Full-subtractor bit slice, start acceptance and last-bit detection.
    always_comb begin
        w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
        w_brw_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);
        // Overflow only possible when operand signs differ; the bit being
        // produced on the last step is the result MSB.
        w_ovf      = (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = start;
            ST_DONE: w_accept = start;
            ST_RUN:  w_last   = (r_cnt == CNT_LAST);
            default: begin
                w_accept = 1'b0;
                w_last   = 1'b0;
            end
        endcase
    end

    // Control FSM: state, busy and the one-cycle done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_done <= 1'b0;
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // A start here chains directly into the next operation.
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_done <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and serial shift datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_d_sr  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= CNT_ZERO;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_cnt   <= CNT_ZERO;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Result registers: written once, on the final serial step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_diff <= {w_d, r_d_sr[WIDTH-1:1]};
            r_bout <= w_brw_next;
            r_ovf  <= w_ovf;
        end else begin
            r_diff <= r_diff;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
